// File: rtl/i2c_accel_sequencer_if.sv
// i2c_accel_sequencer_if: command/response bundle between the sequencer and the I2C master
interface i2c_accel_sequencer_if;
  logic       M_Start;
  logic       M_Write;
  logic [1:0] M_Num_Bytes;
  logic [6:0] M_Address;
  logic [7:0] M_Register;
  logic [7:0] M_Data_Tx;
  logic       M_Buff_Next;
  logic       M_DV;
  logic       M_Busy;
  logic [7:0] M_Data_Rx;
  modport master (
    output M_Start, M_Write, M_Num_Bytes, M_Address, M_Register, M_Data_Tx,
    input  M_Buff_Next, M_DV, M_Busy, M_Data_Rx
  );
  modport slave (
    input  M_Start, M_Write, M_Num_Bytes, M_Address, M_Register, M_Data_Tx,
    output M_Buff_Next, M_DV, M_Busy, M_Data_Rx
  );
endinterface

// File: rtl/i2c_accel_sequencer.sv
// i2c_accel_sequencer: ADXL345 init script then periodic single-byte reads of the six axis registers
module i2c_accel_sequencer #(
  parameter logic [6:0] SLAVE_ADDR = 7'h53,
  parameter int         POLL_DIV   = 500000,
  parameter int         TIMEOUT    = 4096
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Enable,
  i2c_accel_sequencer_if.master        m,
  output logic                         Init_Done,
  output logic [15:0]                  X_Data,
  output logic [15:0]                  Y_Data,
  output logic [15:0]                  Z_Data,
  output logic                         Sample_Valid,
  output logic                         Error
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] XFER  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] WAIT  = 3'd4;
  localparam logic [2:0] ERROR = 3'd5;
  logic [2:0]      state;
  logic [3:0]      step;
  logic [3:0]      go_step;
  logic            go_issue;
  logic            dv_d;
  logic [31:0]     tmo_cnt;
  logic [31:0]     poll_cnt;
  logic [5:0][7:0] shadow;
  logic [7:0]      go_reg;
  logic [7:0]      go_dat;
  logic            unused;
  assign m.M_Num_Bytes = 2'd1;
  assign m.M_Address   = SLAVE_ADDR;
  assign unused        = m.M_Buff_Next;
  // decide whether a new transaction starts this cycle and which step-table entry it uses
  always_comb begin
    go_issue = (state == IDLE && Enable && !m.M_Busy) ||
               (state == DONE && Enable && step != 4'd2 && step != 4'd8) ||
               (state == WAIT && Enable && !m.M_Busy && poll_cnt >= 32'(POLL_DIV - 1));
    go_step  = state == IDLE ? (Init_Done ? 4'd3 : 4'd0) : state == DONE ? step + 4'd1 : 4'd3;
    go_reg   = go_step == 4'd0 ? 8'h2C : go_step == 4'd1 ? 8'h31 : go_step == 4'd2 ? 8'h2D : 8'h2F + {4'd0, go_step};
    go_dat   = go_step == 4'd0 ? 8'h0A : go_step == 4'd1 ? 8'h0B : go_step == 4'd2 ? 8'h08 : 8'h00;
  end
  // sequencer state, command registers, poll timer and sample capture
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      step         <= '0;
      tmo_cnt      <= '0;
      poll_cnt     <= '0;
      dv_d         <= 1'b0;
      shadow       <= '0;
      m.M_Start    <= 1'b0;
      m.M_Write    <= 1'b0;
      m.M_Register <= '0;
      m.M_Data_Tx  <= '0;
      Init_Done    <= 1'b0;
      X_Data       <= '0;
      Y_Data       <= '0;
      Z_Data       <= '0;
      Sample_Valid <= 1'b0;
      Error        <= 1'b0;
    end else begin
      dv_d         <= m.M_DV;
      Sample_Valid <= 1'b0;
      poll_cnt     <= (state == IDLE || (go_issue && go_step == 4'd3)) ? '0 : poll_cnt + {31'd0, poll_cnt != '1};
      if (go_issue) begin
        state        <= ISSUE;
        step         <= go_step;
        tmo_cnt      <= '0;
        m.M_Start    <= 1'b1;
        m.M_Write    <= go_step < 4'd3;
        m.M_Register <= go_reg;
        m.M_Data_Tx  <= go_dat;
      end else begin
        case (state)
          ISSUE: begin
            if (m.M_Busy) begin
              state     <= XFER;
              m.M_Start <= 1'b0;
            end else if (tmo_cnt == 32'(TIMEOUT - 1)) begin
              state     <= ERROR;
              m.M_Start <= 1'b0;
              Error     <= 1'b1;
            end else tmo_cnt <= tmo_cnt + 32'd1;
          end
          XFER: begin
            if (m.M_DV && !dv_d && step >= 4'd3) shadow[3'(step - 4'd3)] <= m.M_Data_Rx;
            if (!m.M_Busy) state <= DONE;
          end
          DONE: begin
            if (step == 4'd2) begin
              Init_Done <= 1'b1;
              state     <= WAIT;
            end else if (step == 4'd8 && Enable) begin
              X_Data       <= {shadow[1], shadow[0]};
              Y_Data       <= {shadow[3], shadow[2]};
              Z_Data       <= {shadow[5], shadow[4]};
              Sample_Valid <= 1'b1;
              state        <= WAIT;
            end else state <= IDLE;
          end
          WAIT: if (!Enable) state <= IDLE;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_accel_sequencer.sv
// tb_i2c_accel_sequencer: randomized master model with command and sample scoreboards
module tb_i2c_accel_sequencer;
  localparam int POLL = 20000;
  localparam int TMO  = 1200;
  typedef struct packed {logic wr; logic [7:0] rg; logic [7:0] dat;} cmd_t;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Enable = 1'b0;
  logic        Init_Done, Sample_Valid, Error;
  logic [15:0] X_Data, Y_Data, Z_Data;
  i2c_accel_sequencer_if bus();
  i2c_accel_sequencer #(.SLAVE_ADDR(7'h53), .POLL_DIV(POLL), .TIMEOUT(TMO)) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .m(bus),
    .Init_Done(Init_Done), .X_Data(X_Data), .Y_Data(Y_Data), .Z_Data(Z_Data),
    .Sample_Valid(Sample_Valid), .Error(Error)
  );
  always #5 Clk = ~Clk;
  int          vec = 0;
  int          bad = 0;
  int          cyc = 0;
  cmd_t        exp_cmd[$];
  logic [47:0] exp_smp[$];
  cmd_t        e;
  logic [7:0]  cur_reg = 8'h00;
  logic        cur_wr = 1'b0;
  int          wr_cnt = 0;
  logic        no_busy = 1'b0;
  logic        use_fixed = 1'b1;
  logic [7:0]  skip_reg = 8'h00;
  logic [7:0]  last_b[6] = '{default: 8'h00};
  logic [7:0]  fixed_b[6] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h00};
  int          t_prev = -1;
  int          nsmp = 0;
  int          rises = 0;
  int          hi_cnt = 0;
  logic        start_q = 1'b0;
  logic        busy_q = 1'b0;
  logic        rise_pend = 1'b0;
  logic        expect_timeout = 1'b0;
  logic        timeout_seen = 1'b0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    vec++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic push_reads();
    for (int i = 0; i < 6; i++) exp_cmd.push_back('{1'b0, 8'h32 + 8'(i), 8'h00});
  endtask
  task automatic push_init();
    exp_cmd.push_back('{1'b1, 8'h2C, 8'h0A});
    exp_cmd.push_back('{1'b1, 8'h31, 8'h0B});
    exp_cmd.push_back('{1'b1, 8'h2D, 8'h08});
    push_reads();
  endtask
  task automatic chk_reset(string tag);
    chk({tag, "_cmd"}, {bus.M_Start, bus.M_Write, bus.M_Num_Bytes, bus.M_Register, bus.M_Data_Tx}, {1'b0, 1'b0, 2'd1, 16'h0000});
    chk({tag, "_xyz"}, {X_Data, Y_Data, Z_Data}, 64'h0);
    chk({tag, "_flags"}, {Init_Done, Sample_Valid, Error}, 64'h0);
  endtask
  always @(posedge Clk) cyc <= cyc + 1;
  // behavioural I2C master: Busy rises 600 cycles after Start, DV once mid-transfer for reads
  initial begin
    int n, dv_at, idx;
    logic [7:0] b;
    bus.M_Busy = 1'b0;
    bus.M_DV = 1'b0;
    bus.M_Data_Rx = 8'h00;
    bus.M_Buff_Next = 1'b0;
    forever begin
      tick();
      if (bus.M_Start && !bus.M_Busy && !no_busy) begin
        cur_reg = bus.M_Register;
        cur_wr = bus.M_Write;
        repeat (599) tick();
        bus.M_Busy = 1'b1;
        n = $urandom_range(60, 20);
        dv_at = $urandom_range(n - 4, 2);
        for (int i = 0; i < n; i++) begin
          tick();
          bus.M_Buff_Next = cur_wr && i == 1;
          if (!cur_wr && i == dv_at && cur_reg != skip_reg && cur_reg >= 8'h32 && cur_reg <= 8'h37) begin
            idx = int'(cur_reg - 8'h32);
            b = use_fixed ? fixed_b[idx] : 8'($urandom);
            bus.M_Data_Rx = b;
            bus.M_DV = 1'b1;
            last_b[idx] = b;
          end
        end
        tick();
        bus.M_Busy = 1'b0;
        bus.M_DV = 1'b0;
        if (cur_wr) wr_cnt++;
        if (!cur_wr && cur_reg == 8'h37) begin
          exp_smp.push_back({last_b[5], last_b[4], last_b[3], last_b[2], last_b[1], last_b[0]});
          use_fixed = 1'b0;
        end
      end
    end
  end
  // monitor: command scoreboard, poll spacing, Start timing, sample scoreboard
  always @(negedge Clk) begin
    if (bus.M_Start && !start_q) begin
      rises++;
      hi_cnt = 0;
      if (exp_cmd.size() == 0) chk("cmd_unexpected", {bus.M_Write, bus.M_Register}, 64'h1FF);
      else begin
        e = exp_cmd.pop_front();
        chk("cmd", {bus.M_Write, bus.M_Register, bus.M_Write ? bus.M_Data_Tx : 8'h00, bus.M_Address, bus.M_Num_Bytes, bus.M_Busy},
            {e.wr, e.rg, e.wr ? e.dat : 8'h00, 7'h53, 2'd1, 1'b0});
        if (!e.wr && e.rg == 8'h37) push_reads();
        if (!e.wr && e.rg == 8'h32) begin
          if (t_prev >= 0) chk("poll_spacing", 64'(cyc - t_prev), 64'(POLL));
          t_prev = cyc;
        end
      end
    end
    if (bus.M_Start) hi_cnt++;
    if (!bus.M_Start && start_q && expect_timeout) begin
      chk("timeout_len", 64'(hi_cnt), 64'(TMO));
      timeout_seen = 1'b1;
    end
    if (rise_pend) begin
      chk("start_drop", {63'd0, bus.M_Start}, 64'h0);
      rise_pend = 1'b0;
    end
    if (bus.M_Busy && !busy_q) rise_pend = 1'b1;
    if (Sample_Valid) begin
      nsmp++;
      if (exp_smp.size() == 0) chk("sample_unexpected", {Z_Data, Y_Data, X_Data}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("sample", {Z_Data, Y_Data, X_Data}, exp_smp.pop_front());
    end
    start_q = bus.M_Start;
    busy_q = bus.M_Busy;
  end
  // stimulus phases
  initial begin
    int r0;
    repeat (3) tick();
    chk_reset("reset0");
    push_init();
    Enable = 1'b1;
    Reset = 1'b0;
    for (int i = 0; i < 10000 && !Init_Done; i++) tick();
    chk("init_done", {63'd0, Init_Done}, 64'h1);
    chk("init_writes", 64'(wr_cnt), 64'd3);
    for (int i = 0; i < 40000 && nsmp < 1; i++) tick();
    chk("first_sample", {X_Data, Y_Data, Z_Data}, {16'h1234, 16'hABCD, 16'h0001});
    for (int i = 0; i < 25000 && !(bus.M_Busy && !cur_wr && cur_reg == 8'h34); i++) tick();
    chk("drop_point", {cur_wr, cur_reg, bus.M_Busy}, {1'b0, 8'h34, 1'b1});
    Enable = 1'b0;
    for (int i = 0; i < 200 && bus.M_Busy; i++) tick();
    repeat (20) tick();
    exp_cmd.delete();
    t_prev = -1;
    chk("drop_no_sample", 64'(nsmp), 64'd1);
    chk("drop_xyz_kept", {X_Data, Y_Data, Z_Data}, {16'h1234, 16'hABCD, 16'h0001});
    push_reads();
    skip_reg = 8'h36;
    Enable = 1'b1;
    for (int i = 0; i < 10000 && nsmp < 2; i++) tick();
    chk("reenable_sample", 64'(nsmp), 64'd2);
    chk("skip_keeps_old", {56'd0, Z_Data[7:0]}, 64'h01);
    skip_reg = 8'h00;
    for (int i = 0; i < 25000 && !(bus.M_Busy && !cur_wr && cur_reg == 8'h33); i++) tick();
    chk("reset_point", {cur_wr, cur_reg, bus.M_Busy}, {1'b0, 8'h33, 1'b1});
    Reset = 1'b1;
    wr_cnt = 0;
    tick();
    chk_reset("reset_busy");
    repeat (2) tick();
    exp_cmd.delete();
    push_init();
    t_prev = -1;
    Reset = 1'b0;
    for (int i = 0; i < 200 && bus.M_Busy; i++) tick();
    last_b = '{default: 8'h00};
    for (int i = 0; i < 10000 && !Init_Done; i++) tick();
    chk("reinit_done", {63'd0, Init_Done}, 64'h1);
    chk("reinit_writes", 64'(wr_cnt), 64'd3);
    no_busy = 1'b1;
    Reset = 1'b1;
    repeat (2) tick();
    exp_cmd.delete();
    exp_cmd.push_back('{1'b1, 8'h2C, 8'h0A});
    expect_timeout = 1'b1;
    Reset = 1'b0;
    for (int i = 0; i < 3000 && !Error; i++) tick();
    chk("error_set", {63'd0, Error}, 64'h1);
    r0 = rises;
    repeat (3000) tick();
    chk("no_restart", 64'(rises - r0), 64'd0);
    chk("error_sticky", {bus.M_Start, Error}, 64'h1);
    chk("timeout_observed", {63'd0, timeout_seen}, 64'h1);
    chk("samples_drained", 64'(exp_smp.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
